// File: rtl/rd_bus_arbiter.sv
// Two-requester (D-cache / I-cache) read-bus arbiter with round-robin tie break,
// per-requester pending latch, owner-only response routing and a sticky protocol-error flag.
module rd_bus_arbiter #(
  parameter int unsigned AWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dcr_start_rq,
  input  logic [AWIDTH-1:0] dcr_rin_addr,
  input  logic              icr_start_rq,
  input  logic [AWIDTH-1:0] icr_rin_addr,
  output logic              start_rq,
  output logic [AWIDTH-1:0] rin_addr,
  input  logic [127:0]      rdat_m_data,
  input  logic              rdat_m_valid,
  input  logic              finish_mrd,
  output logic [127:0]      dc_rdat_m_data,
  output logic [127:0]      ic_rdat_m_data,
  output logic              dc_rdat_m_valid,
  output logic              ic_rdat_m_valid,
  output logic              dc_finish_mrd,
  output logic              ic_finish_mrd,
  output logic              dc_busy,
  output logic              ic_busy,
  output logic              arb_err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  localparam logic OWN_DC = 1'b0;
  localparam logic OWN_IC = 1'b1;

  logic [1:0]        state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_q, last_d;
  logic              dc_pend_q, dc_pend_d;
  logic              ic_pend_q, ic_pend_d;
  logic [AWIDTH-1:0] dc_addr_q, dc_addr_d;
  logic [AWIDTH-1:0] ic_addr_q, ic_addr_d;
  logic [AWIDTH-1:0] rin_q, rin_d;
  logic              start_q, start_d;
  logic              err_q, err_d;

  logic active, dc_own, ic_own;
  logic dc_acc, ic_acc, dc_rej, ic_rej;
  logic dc_el, ic_el, grant_ic;

  assign active = (state_q != S_IDLE);
  assign dc_own = active & (owner_q == OWN_DC);
  assign ic_own = active & (owner_q == OWN_IC);

  assign dc_busy = dc_pend_q | dc_own;
  assign ic_busy = ic_pend_q | ic_own;

  // A requester that is already pending or in flight cannot queue a second read.
  assign dc_acc = dcr_start_rq & ~dc_busy;
  assign ic_acc = icr_start_rq & ~ic_busy;
  assign dc_rej = dcr_start_rq & dc_busy;
  assign ic_rej = icr_start_rq & ic_busy;

  assign dc_rdat_m_data  = rdat_m_data;
  assign ic_rdat_m_data  = rdat_m_data;
  assign dc_rdat_m_valid = rdat_m_valid & dc_own;
  assign ic_rdat_m_valid = rdat_m_valid & ic_own;
  assign dc_finish_mrd   = finish_mrd & (state_q == S_WAIT) & (owner_q == OWN_DC);
  assign ic_finish_mrd   = finish_mrd & (state_q == S_WAIT) & (owner_q == OWN_IC);

  assign start_rq = start_q;
  assign rin_addr = rin_q;
  assign arb_err  = err_q;

  assign dc_el    = dc_pend_q | dc_acc;
  assign ic_el    = ic_pend_q | ic_acc;
  assign grant_ic = ic_el & (~dc_el | (last_q == OWN_DC));

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    dc_pend_d = dc_pend_q;
    ic_pend_d = ic_pend_q;
    dc_addr_d = dc_addr_q;
    ic_addr_d = ic_addr_q;
    rin_d     = rin_q;
    start_d   = 1'b0;
    err_d     = err_q | dc_rej | ic_rej
              | (rdat_m_valid & (state_q == S_IDLE))
              | (finish_mrd & (state_q != S_WAIT));

    if (dc_acc) begin
      dc_pend_d = 1'b1;
      dc_addr_d = dcr_rin_addr;
    end
    if (ic_acc) begin
      ic_pend_d = 1'b1;
      ic_addr_d = icr_rin_addr;
    end

    case (state_q)
      S_IDLE: begin
        if (dc_el | ic_el) begin
          state_d = S_ISSUE;
          start_d = 1'b1;
          owner_d = grant_ic;
          last_d  = grant_ic;
          // Same-cycle pulse bypasses the latch straight into the bus address.
          if (grant_ic) begin
            ic_pend_d = 1'b0;
            rin_d     = ic_pend_q ? ic_addr_q : icr_rin_addr;
          end else begin
            dc_pend_d = 1'b0;
            rin_d     = dc_pend_q ? dc_addr_q : dcr_rin_addr;
          end
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (finish_mrd) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      owner_q   <= OWN_DC;
      last_q    <= OWN_IC;
      dc_pend_q <= 1'b0;
      ic_pend_q <= 1'b0;
      dc_addr_q <= '0;
      ic_addr_q <= '0;
      rin_q     <= '0;
      start_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      dc_pend_q <= dc_pend_d;
      ic_pend_q <= ic_pend_d;
      dc_addr_q <= dc_addr_d;
      ic_addr_q <= ic_addr_d;
      rin_q     <= rin_d;
      start_q   <= start_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_rd_bus_arbiter.sv
// Bench for rd_bus_arbiter: directed scenarios plus randomized traffic against a
// transaction-level model (who owns the bus, who is waiting, sticky error).
module tb_rd_bus_arbiter;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          dcr_start_rq = 1'b0, icr_start_rq = 1'b0;
  logic [AW-1:0] dcr_rin_addr = '0, icr_rin_addr = '0;
  logic          start_rq;
  logic [AW-1:0] rin_addr;
  logic [127:0]  rdat_m_data = '0;
  logic          rdat_m_valid = 1'b0, finish_mrd = 1'b0;
  logic [127:0]  dc_rdat_m_data, ic_rdat_m_data;
  logic          dc_rdat_m_valid, ic_rdat_m_valid, dc_finish_mrd, ic_finish_mrd;
  logic          dc_busy, ic_busy, arb_err;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rd_bus_arbiter #(.AWIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .dcr_start_rq(dcr_start_rq), .dcr_rin_addr(dcr_rin_addr),
    .icr_start_rq(icr_start_rq), .icr_rin_addr(icr_rin_addr),
    .start_rq(start_rq), .rin_addr(rin_addr),
    .rdat_m_data(rdat_m_data), .rdat_m_valid(rdat_m_valid), .finish_mrd(finish_mrd),
    .dc_rdat_m_data(dc_rdat_m_data), .ic_rdat_m_data(ic_rdat_m_data),
    .dc_rdat_m_valid(dc_rdat_m_valid), .ic_rdat_m_valid(ic_rdat_m_valid),
    .dc_finish_mrd(dc_finish_mrd), .ic_finish_mrd(ic_finish_mrd),
    .dc_busy(dc_busy), .ic_busy(ic_busy), .arb_err(arb_err)
  );

  // Model: bus owner (-1 none, 0 DC, 1 IC), whether this is its first (issue) cycle,
  // who is queued with which address, who won last, the address on the bus.
  int          m_cur;
  bit          m_issue;
  bit          m_pend[2];
  logic [AW-1:0] m_addr[2];
  int          m_last;
  logic [AW-1:0] m_rin;
  bit          m_err;
  logic [AW+7:0] exp_vec;

  function automatic void model_reset();
    m_cur = -1; m_issue = 0; m_pend[0] = 0; m_pend[1] = 0;
    m_addr[0] = '0; m_addr[1] = '0; m_last = 1; m_rin = '0; m_err = 0;
  endfunction

  function automatic void model_eval();
    bit s, dv, iv, df, ifn, db, ib;
    s   = (m_cur != -1) && m_issue;
    dv  = rdat_m_valid && (m_cur == 0);
    iv  = rdat_m_valid && (m_cur == 1);
    df  = finish_mrd && (m_cur == 0) && !m_issue;
    ifn = finish_mrd && (m_cur == 1) && !m_issue;
    db  = m_pend[0] || (m_cur == 0);
    ib  = m_pend[1] || (m_cur == 1);
    exp_vec = {s, m_rin, dv, iv, df, ifn, db, ib, m_err};
  endfunction

  function automatic void model_advance();
    bit pul[2];
    logic [AW-1:0] pa[2];
    int g;
    pul[0] = dcr_start_rq; pul[1] = icr_start_rq;
    pa[0] = dcr_rin_addr;  pa[1] = icr_rin_addr;
    for (int r = 0; r < 2; r++) begin
      if (pul[r]) begin
        if (m_pend[r] || m_cur == r) m_err = 1;
        else begin m_pend[r] = 1; m_addr[r] = pa[r]; end
      end
    end
    if (rdat_m_valid && m_cur == -1) m_err = 1;
    if (finish_mrd && (m_cur == -1 || m_issue)) m_err = 1;
    if (m_cur == -1) begin
      if (m_pend[0] || m_pend[1]) begin
        if (m_pend[0] && m_pend[1]) g = 1 - m_last;
        else g = m_pend[0] ? 0 : 1;
        m_rin = m_addr[g]; m_pend[g] = 0; m_cur = g; m_issue = 1; m_last = g;
      end
    end else if (m_issue) m_issue = 0;
    else if (finish_mrd) m_cur = -1;
  endfunction

  task automatic idle_inputs();
    dcr_start_rq = 0; icr_start_rq = 0; rdat_m_valid = 0; finish_mrd = 0;
  endtask

  task automatic settle();
    #1;
    model_eval();
  endtask

  task automatic tick();
    if (rst_n) model_advance();
    @(posedge clk);
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic do_reset();
    rst_n = 0;
    #1;
    model_reset();
    @(negedge clk);
    rst_n = 1;
    idle_inputs();
  endtask

  task automatic test_reset();
    #2 rst_n = 0;
    model_reset();
    @(negedge clk);
    settle();
    checks++; if (start_rq !== 1'b0) begin failures++; $display("FAIL reset_start act=%0b exp=0", start_rq); end
    checks++; if (rin_addr !== '0) begin failures++; $display("FAIL reset_rin act=%h exp=0", rin_addr); end
    checks++; if ({dc_busy, ic_busy, arb_err} !== 3'b000) begin failures++; $display("FAIL reset_flags act=%b exp=000", {dc_busy, ic_busy, arb_err}); end
    checks++; if ({dc_rdat_m_valid, ic_rdat_m_valid, dc_finish_mrd, ic_finish_mrd} !== 4'b0) begin failures++; $display("FAIL reset_routes act=%b exp=0000", {dc_rdat_m_valid, ic_rdat_m_valid, dc_finish_mrd, ic_finish_mrd}); end
    rst_n = 1;
    tick();
  endtask

  task automatic test_single_dc();
    int beats = 0;
    dcr_start_rq = 1; dcr_rin_addr = 32'h0000_1230;
    settle();
    checks++; if (start_rq !== 1'b0) begin failures++; $display("FAIL single_pre_start act=%0b exp=0", start_rq); end
    tick(); settle();
    checks++; if (start_rq !== 1'b1) begin failures++; $display("FAIL single_start act=%0b exp=1", start_rq); end
    checks++; if (rin_addr !== 32'h0000_1230) begin failures++; $display("FAIL single_rin act=%h exp=00001230", rin_addr); end
    checks++; if (dc_busy !== 1'b1) begin failures++; $display("FAIL single_busy act=%0b exp=1", dc_busy); end
    tick(); settle();
    checks++; if (start_rq !== 1'b0) begin failures++; $display("FAIL single_start_one act=%0b exp=0", start_rq); end
    for (int i = 0; i < 4; i++) begin
      rdat_m_valid = 1; rdat_m_data = {4{$urandom}};
      settle();
      if (dc_rdat_m_valid === 1'b1 && ic_rdat_m_valid === 1'b0 && dc_rdat_m_data === rdat_m_data) beats++;
      tick();
    end
    checks++; if (beats !== 4) begin failures++; $display("FAIL single_beats act=%0d exp=4", beats); end
    finish_mrd = 1; settle();
    checks++; if ({dc_finish_mrd, ic_finish_mrd} !== 2'b10) begin failures++; $display("FAIL single_finish act=%b exp=10", {dc_finish_mrd, ic_finish_mrd}); end
    tick(); settle();
    checks++; if ({dc_busy, start_rq, arb_err} !== 3'b000) begin failures++; $display("FAIL single_idle act=%b exp=000", {dc_busy, start_rq, arb_err}); end
  endtask

  task automatic test_tie_rr();
    logic [AW-1:0] ra[4];
    int fin_cycle, got;
    do_reset();
    for (int round = 0; round < 2; round++) begin
      dcr_start_rq = 1; icr_start_rq = 1;
      dcr_rin_addr = 32'h100 + round; icr_rin_addr = 32'h200 + round;
      settle(); tick(); settle();
      ra[2*round] = rin_addr;
      checks++; if ({start_rq, ra[2*round]} !== {1'b1, 32'h100 + round}) begin failures++; $display("FAIL tie_first%0d act=%0b/%h exp=1/%h", round, start_rq, ra[2*round], 32'h100 + round); end
      tick(); settle();
      checks++; if (ic_busy !== 1'b1) begin failures++; $display("FAIL tie_icbusy%0d act=%0b exp=1", round, ic_busy); end
      finish_mrd = 1; settle();
      checks++; if (dc_finish_mrd !== 1'b1) begin failures++; $display("FAIL tie_dcfin%0d act=%0b exp=1", round, dc_finish_mrd); end
      fin_cycle = 0; got = -1;
      for (int c = 1; c <= 4; c++) begin
        tick(); settle();
        if (start_rq === 1'b1 && got < 0) begin got = c; ra[2*round+1] = rin_addr; end
      end
      checks++; if (got !== 2) begin failures++; $display("FAIL tie_latency%0d act=%0d exp=2", round, got); end
      checks++; if (ra[2*round+1] !== 32'h200 + round) begin failures++; $display("FAIL tie_second%0d act=%h exp=%h", round, ra[2*round+1], 32'h200 + round); end
      finish_mrd = 1; settle();
      checks++; if (ic_finish_mrd !== 1'b1) begin failures++; $display("FAIL tie_icfin%0d act=%0b exp=1", round, ic_finish_mrd); end
      tick();
    end
  endtask

  task automatic test_ic_during_wait();
    int early = 0;
    do_reset();
    dcr_start_rq = 1; dcr_rin_addr = 32'h0000_1000;
    settle(); tick(); tick();
    icr_start_rq = 1; icr_rin_addr = 32'h0000_4000;
    settle(); tick(); settle();
    checks++; if (ic_busy !== 1'b1) begin failures++; $display("FAIL wait_icbusy act=%0b exp=1", ic_busy); end
    for (int i = 0; i < 3; i++) begin tick(); settle(); if (start_rq !== 1'b0) early++; end
    checks++; if (early !== 0) begin failures++; $display("FAIL wait_nostart act=%0d exp=0", early); end
    icr_rin_addr = 32'hDEAD_BEEF;
    finish_mrd = 1; settle(); tick(); tick(); settle();
    checks++; if ({start_rq, rin_addr} !== {1'b1, 32'h0000_4000}) begin failures++; $display("FAIL wait_icaddr act=%0b/%h exp=1/00004000", start_rq, rin_addr); end
    tick(); finish_mrd = 1; settle(); tick();
  endtask

  task automatic test_double_pulse();
    int starts = 0;
    do_reset();
    dcr_start_rq = 1; dcr_rin_addr = 32'h0000_5550;
    settle(); tick();
    dcr_start_rq = 1; dcr_rin_addr = 32'h0000_6660;
    settle();
    checks++; if (arb_err !== 1'b0) begin failures++; $display("FAIL dbl_err_early act=%0b exp=0", arb_err); end
    tick(); settle();
    checks++; if ({arb_err, rin_addr} !== {1'b1, 32'h0000_5550}) begin failures++; $display("FAIL dbl_err act=%0b/%h exp=1/00005550", arb_err, rin_addr); end
    finish_mrd = 1; settle(); tick();
    for (int i = 0; i < 5; i++) begin settle(); if (start_rq === 1'b1) starts++; tick(); end
    checks++; if ({starts, dc_busy} !== {32'd0, 1'b0}) begin failures++; $display("FAIL dbl_single act=%0d/%0b exp=0/0", starts, dc_busy); end
  endtask

  task automatic test_idle_bus_err();
    do_reset();
    rdat_m_valid = 1; settle();
    checks++; if ({dc_rdat_m_valid, ic_rdat_m_valid} !== 2'b00) begin failures++; $display("FAIL idle_valid act=%b exp=00", {dc_rdat_m_valid, ic_rdat_m_valid}); end
    tick(); settle();
    checks++; if (arb_err !== 1'b1) begin failures++; $display("FAIL idle_valid_err act=%0b exp=1", arb_err); end
    do_reset(); settle();
    checks++; if (arb_err !== 1'b0) begin failures++; $display("FAIL idle_err_clear act=%0b exp=0", arb_err); end
    finish_mrd = 1; settle();
    checks++; if ({dc_finish_mrd, ic_finish_mrd} !== 2'b00) begin failures++; $display("FAIL idle_fin act=%b exp=00", {dc_finish_mrd, ic_finish_mrd}); end
    tick();
    for (int i = 0; i < 6; i++) tick();
    settle();
    checks++; if (arb_err !== 1'b1) begin failures++; $display("FAIL idle_sticky act=%0b exp=1", arb_err); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    dcr_start_rq = 1; dcr_rin_addr = 32'h0000_2220;
    settle(); tick(); tick();
    rst_n = 0; rdat_m_valid = 1; finish_mrd = 1;
    #1; model_reset();
    checks++; if ({start_rq, rin_addr, dc_busy, dc_rdat_m_valid, dc_finish_mrd, arb_err} !== '0) begin failures++; $display("FAIL mid_reset act=%0b/%h/%0b%0b%0b%0b exp=0", start_rq, rin_addr, dc_busy, dc_rdat_m_valid, dc_finish_mrd, arb_err); end
    @(negedge clk); rst_n = 1; idle_inputs();
    dcr_start_rq = 1; dcr_rin_addr = 32'h0000_7770;
    settle(); tick(); settle();
    checks++; if ({start_rq, rin_addr, arb_err} !== {1'b1, 32'h0000_7770, 1'b0}) begin failures++; $display("FAIL mid_fresh act=%0b/%h/%0b exp=1/00007770/0", start_rq, rin_addr, arb_err); end
    tick(); finish_mrd = 1; settle(); tick();
  endtask

  task automatic test_random();
    int bad = 0;
    logic [AW+7:0] obs;
    do_reset();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      if (cyc % 150 == 149) do_reset();
      dcr_start_rq = ($urandom_range(0, 4) == 0);
      icr_start_rq = ($urandom_range(0, 4) == 0);
      dcr_rin_addr = $urandom; icr_rin_addr = $urandom;
      rdat_m_data  = {$urandom, $urandom, $urandom, $urandom};
      rdat_m_valid = (m_cur != -1) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 40) == 0);
      finish_mrd   = (m_cur != -1 && !m_issue) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 40) == 0);
      settle();
      obs = {start_rq, rin_addr, dc_rdat_m_valid, ic_rdat_m_valid, dc_finish_mrd, ic_finish_mrd, dc_busy, ic_busy, arb_err};
      checks++;
      if (obs !== exp_vec) begin
        failures++; bad++;
        if (bad < 10) $display("FAIL rand_out cyc=%0d act=%h exp=%h", cyc, obs, exp_vec);
      end
      checks++;
      if (dc_rdat_m_data !== rdat_m_data || ic_rdat_m_data !== rdat_m_data) begin
        failures++; bad++;
        if (bad < 10) $display("FAIL rand_data cyc=%0d act=%h/%h exp=%h", cyc, dc_rdat_m_data, ic_rdat_m_data, rdat_m_data);
      end
      tick();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog act=timeout exp=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    test_reset();
    test_single_dc();
    test_tie_rr();
    test_ic_during_wait();
    test_double_pulse();
    test_idle_bus_err();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
